// File: rtl/nc_pkg.sv
// Shared NeuroCuts leaf-engine types: 5-tuple header layout, rule record and
// the reference rule-match predicate used by software-side checkers.
package nc_pkg;

  localparam int NC_IP_W    = 32;
  localparam int NC_PORT_W  = 16;
  localparam int NC_PROTO_W = 8;
  localparam int NC_PRIO_W  = 8;
  localparam int NC_PKT_W   = 2*NC_IP_W + 2*NC_PORT_W + NC_PROTO_W;

  typedef struct packed {
    logic [NC_IP_W-1:0]    src_ip;
    logic [NC_IP_W-1:0]    dst_ip;
    logic [NC_PORT_W-1:0]  src_port;
    logic [NC_PORT_W-1:0]  dst_port;
    logic [NC_PROTO_W-1:0] proto;
  } pkt_hdr_t;

  typedef struct packed {
    logic                 en;
    pkt_hdr_t             lo;
    pkt_hdr_t             hi;
    logic [NC_PRIO_W-1:0] prio;
  } rule_t;

  // Inclusive unsigned range test on every field; lo > hi simply never matches.
  function automatic logic hdr_in_rule(rule_t r, pkt_hdr_t h);
    return r.en &&
           (h.src_ip   >= r.lo.src_ip)   && (h.src_ip   <= r.hi.src_ip)   &&
           (h.dst_ip   >= r.lo.dst_ip)   && (h.dst_ip   <= r.hi.dst_ip)   &&
           (h.src_port >= r.lo.src_port) && (h.src_port <= r.hi.src_port) &&
           (h.dst_port >= r.lo.dst_port) && (h.dst_port <= r.hi.dst_port) &&
           (h.proto    >= r.lo.proto)    && (h.proto    <= r.hi.proto);
  endfunction

endpackage

// File: rtl/rule_table_matcher_if.sv
// Config, packet and result channels of the rule table matcher.
interface rule_table_matcher_if #(
  parameter int IDX_W  = 4,
  parameter int PKT_W  = 104,
  parameter int PRIO_W = 8
);
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_en;
  logic [PKT_W-1:0]  cfg_lo;
  logic [PKT_W-1:0]  cfg_hi;
  logic [PRIO_W-1:0] cfg_prio;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [PKT_W-1:0]  pkt_hdr;

  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [IDX_W-1:0]  res_idx;
  logic [PRIO_W-1:0] res_prio;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_lo, cfg_hi, cfg_prio,
    output pkt_valid, pkt_hdr, res_ready,
    input  pkt_ready, res_valid, res_hit, res_idx, res_prio
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_lo, cfg_hi, cfg_prio,
    input  pkt_valid, pkt_hdr, res_ready,
    output pkt_ready, res_valid, res_hit, res_idx, res_prio
  );
endinterface

// File: rtl/rule_prio_select.sv
// Combinational winner selection: highest priority among matching rules,
// lowest index on ties, via a binary tournament tree.
module rule_prio_select #(
  parameter  int NUM_RULES = 16,
  parameter  int PRIO_W    = 8,
  localparam int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic [NUM_RULES-1:0]             match_vec,
  input  logic [NUM_RULES-1:0][PRIO_W-1:0] prio,
  output logic                             hit,
  output logic [IDX_W-1:0]                 idx,
  output logic [PRIO_W-1:0]                win_prio
);

  logic              node_v [2*NUM_RULES];
  logic [PRIO_W-1:0] node_p [2*NUM_RULES];
  logic [IDX_W-1:0]  node_i [2*NUM_RULES];

  // Heap layout: leaves at NUM_RULES+r, node n combines 2n and 2n+1, root is 1.
  // The right child wins only with strictly greater priority, keeping ties low.
  always_comb begin
    for (int n = 0; n < 2*NUM_RULES; n++) begin
      node_v[n] = 1'b0;
      node_p[n] = '0;
      node_i[n] = '0;
    end
    for (int r = 0; r < NUM_RULES; r++) begin
      node_v[NUM_RULES+r] = match_vec[r];
      node_p[NUM_RULES+r] = prio[r];
      node_i[NUM_RULES+r] = IDX_W'(r);
    end
    for (int n = NUM_RULES-1; n >= 1; n--) begin
      if (node_v[2*n+1] && (!node_v[2*n] || (node_p[2*n+1] > node_p[2*n]))) begin
        node_v[n] = 1'b1;
        node_p[n] = node_p[2*n+1];
        node_i[n] = node_i[2*n+1];
      end else begin
        node_v[n] = node_v[2*n];
        node_p[n] = node_p[2*n];
        node_i[n] = node_i[2*n];
      end
    end
    hit      = node_v[1];
    idx      = node_v[1] ? node_i[1] : '0;
    win_prio = node_v[1] ? node_p[1] : '0;
  end

endmodule

// File: rtl/rule_table_matcher.sv
// N-rule 5-tuple range classifier: S1 captures the parallel match vector,
// S2 registers the priority winner. Table is flop-based for parallel reads.
module rule_table_matcher import nc_pkg::*; #(
  parameter  int NUM_RULES = 16,
  parameter  int IP_W      = NC_IP_W,
  parameter  int PORT_W    = NC_PORT_W,
  parameter  int PROTO_W   = NC_PROTO_W,
  parameter  int PRIO_W    = NC_PRIO_W,
  localparam int IDX_W     = $clog2(NUM_RULES),
  localparam int PKT_W     = 2*IP_W + 2*PORT_W + PROTO_W
) (
  input logic                 clk,
  input logic                 rst_n,
  rule_table_matcher_if.slave bus
);

  localparam int DPORT_LSB = PROTO_W;
  localparam int SPORT_LSB = PROTO_W + PORT_W;
  localparam int DIP_LSB   = PROTO_W + 2*PORT_W;
  localparam int SIP_LSB   = DIP_LSB + IP_W;

  logic [NUM_RULES-1:0]             tbl_en;
  logic [PKT_W-1:0]                 tbl_lo [NUM_RULES];
  logic [PKT_W-1:0]                 tbl_hi [NUM_RULES];
  logic [NUM_RULES-1:0][PRIO_W-1:0] tbl_prio;

  logic [NUM_RULES-1:0]             match_vec;
  logic                             s1_valid;
  logic [NUM_RULES-1:0]             s1_vec;
  logic [NUM_RULES-1:0][PRIO_W-1:0] s1_prio;

  logic                             sel_hit;
  logic [IDX_W-1:0]                 sel_idx;
  logic [PRIO_W-1:0]                sel_prio;

  logic                             res_valid_q;
  logic                             res_hit_q;
  logic [IDX_W-1:0]                 res_idx_q;
  logic [PRIO_W-1:0]                res_prio_q;
  logic                             advance;

  function automatic logic in_range(logic [PKT_W-1:0] lo, logic [PKT_W-1:0] hi,
                                    logic [PKT_W-1:0] h);
    return (h[SIP_LSB +: IP_W]     >= lo[SIP_LSB +: IP_W])     && (h[SIP_LSB +: IP_W]     <= hi[SIP_LSB +: IP_W])     &&
           (h[DIP_LSB +: IP_W]     >= lo[DIP_LSB +: IP_W])     && (h[DIP_LSB +: IP_W]     <= hi[DIP_LSB +: IP_W])     &&
           (h[SPORT_LSB +: PORT_W] >= lo[SPORT_LSB +: PORT_W]) && (h[SPORT_LSB +: PORT_W] <= hi[SPORT_LSB +: PORT_W]) &&
           (h[DPORT_LSB +: PORT_W] >= lo[DPORT_LSB +: PORT_W]) && (h[DPORT_LSB +: PORT_W] <= hi[DPORT_LSB +: PORT_W]) &&
           (h[0 +: PROTO_W]        >= lo[0 +: PROTO_W])        && (h[0 +: PROTO_W]        <= hi[0 +: PROTO_W]);
  endfunction

  assign advance       = !res_valid_q || bus.res_ready;
  assign bus.pkt_ready = !s1_valid || advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_en   <= '0;
      tbl_prio <= '0;
      for (int r = 0; r < NUM_RULES; r++) begin
        tbl_lo[r] <= '0;
        tbl_hi[r] <= '0;
      end
    end else if (bus.cfg_we) begin
      tbl_en[bus.cfg_idx]   <= bus.cfg_en;
      tbl_lo[bus.cfg_idx]   <= bus.cfg_lo;
      tbl_hi[bus.cfg_idx]   <= bus.cfg_hi;
      tbl_prio[bus.cfg_idx] <= bus.cfg_prio;
    end
  end

  always_comb begin
    match_vec = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      match_vec[r] = tbl_en[r] && in_range(tbl_lo[r], tbl_hi[r], bus.pkt_hdr);
    end
  end

  // Priorities are snapshotted with the vector so a later table write cannot
  // alter the result of a packet already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_prio  <= '0;
    end else if (bus.pkt_ready) begin
      s1_valid <= bus.pkt_valid;
      if (bus.pkt_valid) begin
        s1_vec  <= match_vec;
        s1_prio <= tbl_prio;
      end
    end
  end

  rule_prio_select #(
    .NUM_RULES (NUM_RULES),
    .PRIO_W    (PRIO_W)
  ) u_select (
    .match_vec (s1_vec),
    .prio      (s1_prio),
    .hit       (sel_hit),
    .idx       (sel_idx),
    .win_prio  (sel_prio)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      res_prio_q  <= '0;
    end else if (advance) begin
      res_valid_q <= s1_valid;
      if (s1_valid) begin
        res_hit_q  <= sel_hit;
        res_idx_q  <= sel_idx;
        res_prio_q <= sel_prio;
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_prio  = res_prio_q;

endmodule

// File: tb/tb_rule_table_matcher.sv
// Scoreboard bench for rule_table_matcher: a sequential-scan reference model
// predicts each result at acceptance; a negedge monitor checks it on output.
module tb_rule_table_matcher;
  import nc_pkg::*;

  localparam int NUM_RULES = 16;
  localparam int IDX_W     = 4;
  localparam int PRIO_W    = NC_PRIO_W;
  localparam int PKT_W     = NC_PKT_W;

  typedef logic [IDX_W+PRIO_W:0] res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rule_table_matcher_if #(.IDX_W(IDX_W), .PKT_W(PKT_W), .PRIO_W(PRIO_W)) bus ();

  rule_table_matcher #(.NUM_RULES(NUM_RULES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rule_t model_tbl [NUM_RULES];
  res_t  exp_q [$];
  int    total_checks  = 0;
  int    bad_checks    = 0;
  int    results_seen  = 0;
  int    ready_low_cnt = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
    end
  endtask

  // Ascending scan with strict '>' gives lowest-index-wins on equal priority.
  function automatic res_t model_result(pkt_hdr_t h);
    logic              hit = 1'b0;
    logic [IDX_W-1:0]  idx = '0;
    logic [PRIO_W-1:0] p   = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      if (hdr_in_rule(model_tbl[r], h) && (!hit || model_tbl[r].prio > p)) begin
        hit = 1'b1;
        idx = IDX_W'(r);
        p   = model_tbl[r].prio;
      end
    end
    return {hit, idx, p};
  endfunction

  function automatic pkt_hdr_t mk_hdr(logic [31:0] sip, logic [31:0] dip,
                                      logic [15:0] sp, logic [15:0] dp, logic [7:0] pr);
    pkt_hdr_t h;
    h.src_ip = sip; h.dst_ip = dip; h.src_port = sp; h.dst_port = dp; h.proto = pr;
    return h;
  endfunction

  // Queue length at a negedge equals packets in flight, so two entries means both stages full.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pkt_ready", bus.pkt_ready, !(exp_q.size() == 2 && !bus.res_ready));
      if (!bus.pkt_ready) ready_low_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("res_valid_idle", bus.res_valid, 1'b0);
      end else if (bus.res_valid) begin
        checkOutput(bus.res_ready ? "result" : "stall_hold",
                    {bus.res_hit, bus.res_idx, bus.res_prio}, exp_q[0]);
        if (bus.res_ready) begin
          void'(exp_q.pop_front());
          results_seen++;
        end
      end
      if (bus.pkt_valid && bus.pkt_ready) exp_q.push_back(model_result(pkt_hdr_t'(bus.pkt_hdr)));
      if (bus.cfg_we) begin
        model_tbl[bus.cfg_idx].en   = bus.cfg_en;
        model_tbl[bus.cfg_idx].lo   = pkt_hdr_t'(bus.cfg_lo);
        model_tbl[bus.cfg_idx].hi   = pkt_hdr_t'(bus.cfg_hi);
        model_tbl[bus.cfg_idx].prio = bus.cfg_prio;
      end
    end
  end

  task automatic writeRule(input int idx, input logic en, input pkt_hdr_t lo,
                           input pkt_hdr_t hi, input logic [PRIO_W-1:0] prio);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = IDX_W'(idx);
    bus.cfg_en   = en;
    bus.cfg_lo   = lo;
    bus.cfg_hi   = hi;
    bus.cfg_prio = prio;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic applyStimulus(input pkt_hdr_t hdr);
    logic accepted = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.pkt_hdr   = hdr;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      accepted = bus.pkt_ready;
      @(posedge clk); #1;
    end
    bus.pkt_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    checkOutput("drain", exp_q.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, bus.pkt_ready, 1'b1);
    checkOutput({tag, "_valid"}, bus.res_valid, 1'b0);
    checkOutput({tag, "_res"}, {bus.res_hit, bus.res_idx, bus.res_prio}, '0);
  endtask

  task automatic clearModel();
    for (int r = 0; r < NUM_RULES; r++) model_tbl[r] = '0;
    exp_q.delete();
  endtask

  initial begin
    pkt_hdr_t lo, hi;
    pkt_hdr_t stream [8];
    int base;

    clearModel();
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
    bus.cfg_lo = '0; bus.cfg_hi = '0; bus.cfg_prio = '0;
    bus.pkt_valid = 1'b0; bus.pkt_hdr = '0; bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset state and empty-table latency");
    checkResetState("rst");
    bus.pkt_valid = 1'b1;
    bus.pkt_hdr   = mk_hdr(32'hC0A80001, 32'h08080808, 16'd1000, 16'd53, 8'd17);
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
    checkOutput("lat_t1", bus.res_valid, 1'b0);
    @(posedge clk); #1;
    checkOutput("lat_t2", bus.res_valid, 1'b1);
    checkOutput("empty_res", {bus.res_hit, bus.res_idx, bus.res_prio}, '0);
    waitDrain();

    $display("[TB] single src_ip range rule");
    lo = '0; hi = '1;
    lo.src_ip = 32'h0A000000; hi.src_ip = 32'h0A0000FF;
    writeRule(3, 1'b1, lo, hi, 8'd5);
    applyStimulus(mk_hdr(32'h0A000007, 32'h01020304, 16'd1, 16'd2, 8'd6));
    applyStimulus(mk_hdr(32'h0A000100, 32'h01020304, 16'd1, 16'd2, 8'd6));
    waitDrain();

    $display("[TB] priority ties");
    lo = '0; hi = '1; lo.proto = 8'd17; hi.proto = 8'd17;
    writeRule(1, 1'b1, lo, hi, 8'd9);
    writeRule(6, 1'b1, lo, hi, 8'd9);
    writeRule(2, 1'b1, lo, hi, 8'd4);
    applyStimulus(mk_hdr(32'h0B000000, 32'h0, 16'd5, 16'd5, 8'd17));
    applyStimulus(mk_hdr(32'h0A000007, 32'h0, 16'd5, 16'd5, 8'd17));
    writeRule(1, 1'b0, lo, hi, 8'd9);
    applyStimulus(mk_hdr(32'h0B000000, 32'h0, 16'd5, 16'd5, 8'd17));
    waitDrain();

    $display("[TB] range boundaries");
    lo = '0; hi = '1;
    lo.dst_port = 16'd80; hi.dst_port = 16'd80; lo.proto = 8'd6; hi.proto = 8'd6;
    writeRule(4, 1'b1, lo, hi, 8'd50);
    lo = '0; hi = '1; lo.proto = 8'h0A; hi.proto = 8'h05;
    writeRule(5, 1'b1, lo, hi, 8'd255);
    for (int p = 79; p <= 81; p++) applyStimulus(mk_hdr(32'h0C000000, 32'h0, 16'd1234, 16'(p), 8'd6));
    applyStimulus(mk_hdr(32'h0C000000, 32'h0, 16'd1234, 16'd80, 8'h07));
    applyStimulus(mk_hdr(32'h0C000000, 32'h0, 16'd1234, 16'd80, 8'h0A));
    waitDrain();

    $display("[TB] back-to-back stream with downstream stall");
    for (int i = 0; i < 8; i++) begin
      stream[i] = mk_hdr((i % 2 == 0) ? 32'h0A000010 : 32'h0C000000, 32'(i), 16'd7,
                         16'(79 + (i % 3)), (i % 4 == 3) ? 8'd17 : 8'd6);
    end
    base = results_seen;
    ready_low_cnt = 0;
    fork
      for (int i = 0; i < 8; i++) applyStimulus(stream[i]);
      begin
        repeat (3) @(posedge clk);
        #1 bus.res_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.res_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stream_count", results_seen - base, 8);
    checkOutput("ready_low_cycles", ready_low_cnt, 4);

    $display("[TB] write coinciding with accept, then async reset");
    lo = '0; hi = '1;
    bus.cfg_we = 1'b1; bus.cfg_idx = '0; bus.cfg_en = 1'b1;
    bus.cfg_lo = lo; bus.cfg_hi = hi; bus.cfg_prio = 8'd200;
    bus.pkt_valid = 1'b1;
    bus.pkt_hdr   = mk_hdr(32'h0B000000, 32'h0, 16'd5, 16'd5, 8'd17);
    @(posedge clk); #1;
    bus.cfg_we  = 1'b0;
    bus.pkt_hdr = mk_hdr(32'h0B000001, 32'h0, 16'd5, 16'd5, 8'd17);
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
    waitDrain();

    fork
      for (int i = 0; i < 6; i++) applyStimulus(mk_hdr(32'(i), 32'h0, 16'd1, 16'd1, 8'd1));
      begin
        repeat (3) @(posedge clk);
        #2 checkOutput("pre_reset_valid", bus.res_valid, 1'b1);
        rst_n = 1'b0;
        #1 checkOutput("reset_async_valid", bus.res_valid, 1'b0);
      end
    join
    bus.pkt_valid = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkResetState("rst2");
    applyStimulus(mk_hdr(32'h0B000000, 32'h0, 16'd5, 16'd5, 8'd17));
    waitDrain();

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running want finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
